elevator_sequencer: RTL and testbench

Central controller FSM for the two-landing freight elevator.
- Consumes the latched request and sensor outputs of the transducer block: GU, GL, CU, CL, UES, LES, IS, AU, AL.
- Drives the motor and door command pulses back into it: MU, MD, CUE, CLE, CI, OUE, OLE, OI.
- Sequences open, dwell, close, verify-closed, move and arrive. Flags a sticky fault on door or motor timeouts.

---
 rtl/elevator_pkg.sv | 36 +++
 rtl/elevator_if.sv | 23 ++
 rtl/elevator_timer.sv | 27 ++
 rtl/elevator_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_elevator_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared encodings and timing defaults for the elevator sequencer
// Purpose: state/position encodings, default timing constants and a sizing helper.
// Ports: none (package).
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_OPEN        = 3'd0,
    ST_WAIT_OPEN   = 3'd1,
    ST_DWELL       = 3'd2,
    ST_CLOSE       = 3'd3,
    ST_WAIT_CLOSED = 3'd4,
    ST_MOVE        = 3'd5,
    ST_FAULT       = 3'd6
  } state_e;

  typedef enum logic {
    POS_LOWER = 1'b0,
    POS_UPPER = 1'b1
  } pos_e;

  localparam int DEF_DWELL_CYCLES = 8;
  localparam int DEF_STEP_CYCLES  = 4;
  localparam int DEF_DOOR_TIMEOUT = 16;
  localparam int DEF_MAX_STEPS    = 3;

  // Largest of four timing values; sizes the shared timer.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/elevator_if.sv
// rtl/elevator_if.sv - sensor/request and command-pulse bundle between transducer and sequencer
// Purpose: groups the latched requests/sensors and the motor/door command pulses.
// Ports: master = sequencer (requests/sensors in, pulses out); slave = transducer side.
interface elevator_if;
  // Requests and sensors from the transducer
  logic GU, GL, CU, CL;
  logic UES, LES, IS;
  logic AU, AL;
  // Command pulses to the transducer
  logic MU, MD;
  logic CUE, CLE, CI;
  logic OUE, OLE, OI;

  modport master (
    input  GU, GL, CU, CL, UES, LES, IS, AU, AL,
    output MU, MD, CUE, CLE, CI, OUE, OLE, OI
  );

  modport slave (
    output GU, GL, CU, CL, UES, LES, IS, AU, AL,
    input  MU, MD, CUE, CLE, CI, OUE, OLE, OI
  );
endinterface

// File: rtl/elevator_timer.sv
// rtl/elevator_timer.sv - loadable saturating down-counter with done flag
// Purpose: one timer shared by dwell, step and door-timeout intervals.
// Ports: clk, rst (async, active-high), load_i/value_i load the count, done_o high at zero.
module elevator_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);
  logic [W-1:0] count_q;

  // Stops at zero instead of wrapping, so done_o stays high until reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);
endmodule

// File: rtl/elevator_sequencer.sv
// rtl/elevator_sequencer.sv - central open/dwell/close/move FSM of the two-landing elevator
// Purpose: sequences doors and motor steps, raises a sticky fault on door/motor timeouts.
// Ports: clk, reset (async, active-high), bus (elevator_if.master), state[2:0], fault.
// Optional: ELEVATOR_SEQ_REOPEN_EN - one same-side reopen per stop during CLOSE/WAIT_CLOSED.
module elevator_sequencer
  import elevator_pkg::*;
#(
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int STEP_CYCLES  = DEF_STEP_CYCLES,
  parameter int DOOR_TIMEOUT = DEF_DOOR_TIMEOUT,
  parameter int MAX_STEPS    = DEF_MAX_STEPS
) (
  input  logic       clk,
  input  logic       reset,
  elevator_if.master bus,
  output logic [2:0] state,
  output logic       fault
);
  localparam int TW = $clog2(max4(DWELL_CYCLES, STEP_CYCLES, DOOR_TIMEOUT, MAX_STEPS) + 1);
  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam logic [TW-1:0] T_DOOR  = TW'(DOOR_TIMEOUT);
  // Dwell and step reloads are one short: the cycle of the transition itself counts.
  localparam logic [TW-1:0] T_DWELL = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] T_STEP  = TW'(STEP_CYCLES - 1);
  localparam logic [SW-1:0] S_MAX   = SW'(MAX_STEPS);

  state_e        state_q;
  pos_e          pos_q;
  logic [SW-1:0] steps_q;
  logic          fault_q;
  logic          mu_q, md_q, cue_q, cle_q, ci_q, oue_q, ole_q, oi_q;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;

  logic at_lower, land_open, doors_open, doors_closed, req_opp, arrived, reopen;

  assign at_lower     = (pos_q == POS_LOWER);
  assign land_open    = at_lower ? bus.LES : bus.UES;
  assign doors_open   = bus.IS & land_open;
  assign doors_closed = ~bus.IS & ~land_open;
  // Only calls that send the car to the other landing start a trip.
  assign req_opp      = at_lower ? (bus.GU | bus.CU) : (bus.GL | bus.CL);
  assign arrived      = at_lower ? bus.AU : bus.AL;

`ifdef ELEVATOR_SEQ_REOPEN_EN
  logic same_now, same_q, reopened_q;
  assign same_now = at_lower ? (bus.GL | bus.CL) : (bus.GU | bus.CU);
  // Rising same-side call while closing, once per stop.
  assign reopen   = same_now & ~same_q & ~reopened_q &
                    ((state_q == ST_CLOSE) | (state_q == ST_WAIT_CLOSED));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      same_q     <= 1'b0;
      reopened_q <= 1'b0;
    end else begin
      same_q <= same_now;
      if (reopen) begin
        reopened_q <= 1'b1;
      end else if ((state_q == ST_MOVE) && tmr_done && arrived) begin
        reopened_q <= 1'b0;
      end
    end
  end
`else
  assign reopen = 1'b0;
`endif

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_OPEN, ST_CLOSE: begin
        tmr_load = 1'b1;
        tmr_val  = T_DOOR;
      end
      ST_WAIT_OPEN: if (doors_open) begin
        tmr_load = 1'b1;
        tmr_val  = T_DWELL;
      end
      // Zero load makes the first motor step fire on the first MOVE cycle.
      ST_WAIT_CLOSED: if (doors_closed) begin
        tmr_load = 1'b1;
        tmr_val  = '0;
      end
      ST_MOVE: if (tmr_done && !arrived && (steps_q < S_MAX)) begin
        tmr_load = 1'b1;
        tmr_val  = T_STEP;
      end
      default: ;
    endcase
  end

  elevator_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (reset),
    .load_i (tmr_load),
    .value_i(tmr_val),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OPEN;
      pos_q   <= POS_LOWER;
      steps_q <= '0;
      fault_q <= 1'b0;
      {mu_q, md_q, cue_q, cle_q, ci_q, oue_q, ole_q, oi_q} <= '0;
    end else begin
      {mu_q, md_q, cue_q, cle_q, ci_q, oue_q, ole_q, oi_q} <= '0;
      case (state_q)
        ST_OPEN: begin
          oi_q    <= 1'b1;
          ole_q   <= at_lower;
          oue_q   <= ~at_lower;
          state_q <= ST_WAIT_OPEN;
        end
        ST_WAIT_OPEN: begin
          if (doors_open) begin
            state_q <= ST_DWELL;
          end else if (tmr_done) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end
        end
        ST_DWELL: begin
          if (tmr_done && req_opp) state_q <= ST_CLOSE;
        end
        ST_CLOSE: begin
          if (reopen) begin
            state_q <= ST_OPEN;
          end else begin
            ci_q    <= 1'b1;
            cle_q   <= at_lower;
            cue_q   <= ~at_lower;
            state_q <= ST_WAIT_CLOSED;
          end
        end
        ST_WAIT_CLOSED: begin
          if (reopen) begin
            state_q <= ST_OPEN;
          end else if (doors_closed) begin
            steps_q <= '0;
            state_q <= ST_MOVE;
          end else if (tmr_done) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end
        end
        ST_MOVE: begin
          if (tmr_done) begin
            if (arrived) begin
              pos_q   <= at_lower ? POS_UPPER : POS_LOWER;
              state_q <= ST_OPEN;
            end else if (steps_q >= S_MAX) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              mu_q    <= at_lower;
              md_q    <= ~at_lower;
              steps_q <= steps_q + 1'b1;
            end
          end
        end
        ST_FAULT: fault_q <= 1'b1;
        default: begin
          state_q <= ST_FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.MU  = mu_q;
  assign bus.MD  = md_q;
  assign bus.CUE = cue_q;
  assign bus.CLE = cle_q;
  assign bus.CI  = ci_q;
  assign bus.OUE = oue_q;
  assign bus.OLE = ole_q;
  assign bus.OI  = oi_q;
  assign state   = state_q;
  assign fault   = fault_q;
endmodule

// File: tb/tb_elevator_sequencer.sv
// tb/tb_elevator_sequencer.sv - self-checking bench for elevator_sequencer with a transducer model
module tb_elevator_sequencer;
  localparam int DWELL = 8;
  localparam int STEP  = 4;
  localparam int MAXS  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] state;
  logic       fault;

  elevator_if bus ();

  elevator_sequencer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .state(state),
    .fault(fault)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_p[8];
  int last_motor = -100;
  int open_tick = -100;
  int tot_pulse = 0, tot_motor = 0, tot_close = 0;
  // Transducer model: doors (0 inner, 1 lower, 2 upper), car position, motor steps.
  bit door_val[3];
  bit door_tgt[3];
  int door_cnt[3];
  int door_delay = 0;
  bit door_freeze = 1'b0;
  int mpos = 0;
  int mcount = 0;
  int trip_need = 1;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_door(input int i, input bit v);
    door_tgt[i] = v;
    door_cnt[i] = door_delay;
  endtask

  task automatic drive_doors();
    bus.IS  = door_val[0];
    bus.LES = door_val[1];
    bus.UES = door_val[2];
  endtask

  task automatic env_reset();
    {bus.GU, bus.GL, bus.CU, bus.CL, bus.AU} = '0;
    bus.AL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      door_val[i] = 1'b0; door_tgt[i] = 1'b0; door_cnt[i] = 0;
    end
    door_freeze = 1'b0;
    mpos = 0;
    mcount = 0;
    drive_doors();
  endtask

  task automatic monitor();
    logic [7:0] p;
    p = {bus.MU, bus.MD, bus.CUE, bus.CLE, bus.CI, bus.OUE, bus.OLE, bus.OI};
    for (int i = 0; i < 8; i++) begin
      if (p[i]) begin
        check($sformatf("pulse_gap_%0d", i), int'((cyc - last_p[i]) >= 2), 1);
        last_p[i] = cyc;
        tot_pulse++;
      end
    end
    if (bus.MU || bus.MD) begin
      check("motor_doors_closed", int'(door_val[0] | door_val[1] | door_val[2]), 0);
      check("motor_direction", int'(bus.MU), int'(mpos == 0));
      if (mcount > 0) check("motor_step_gap", cyc - last_motor, STEP);
      last_motor = cyc;
      tot_motor++;
    end
    if (bus.CI) begin
      check("close_opp_request", int'(mpos == 0 ? (bus.GU | bus.CU) : (bus.GL | bus.CL)), 1);
      check("close_landing_lower", int'(bus.CLE), int'(mpos == 0));
      check("close_landing_upper", int'(bus.CUE), int'(mpos == 1));
      check("close_after_dwell", int'((cyc - open_tick) > DWELL), 1);
      tot_close++;
    end
    if (bus.OI) begin
      check("open_landing_lower", int'(bus.OLE), int'(mpos == 0));
      check("open_landing_upper", int'(bus.OUE), int'(mpos == 1));
    end
  endtask

  task automatic env_update();
    bit was_open;
    was_open = door_val[0] && door_val[1 + mpos];
    if (bus.OI) set_door(0, 1'b1);
    if (bus.CI && !door_freeze) set_door(0, 1'b0);
    if (bus.OLE) set_door(1, 1'b1);
    if (bus.CLE) set_door(1, 1'b0);
    if (bus.OUE) set_door(2, 1'b1);
    if (bus.CUE) set_door(2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (door_cnt[i] == 0) door_val[i] = door_tgt[i];
      else door_cnt[i]--;
    end
    if (bus.CI) mcount = 0;
    if (bus.MU || bus.MD) begin
      mcount++;
      bus.AU = 1'b0;
      bus.AL = 1'b0;
      if (mcount == trip_need) begin
        if (bus.MU) begin
          bus.AU = 1'b1; bus.GU = 1'b0; bus.CU = 1'b0; mpos = 1;
        end else begin
          bus.AL = 1'b1; bus.GL = 1'b0; bus.CL = 1'b0; mpos = 0;
        end
      end
    end
    drive_doors();
    if (!was_open && door_val[0] && door_val[1 + mpos]) open_tick = cyc;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor();
    env_update();
  endtask

  task automatic wait_state(input int exp, input int budget, input string tag);
    int n;
    n = 0;
    while (int'(state) != exp && n < budget) begin
      tick();
      n++;
    end
    check(tag, int'(state), exp);
  endtask

  task automatic wait_arrive(input int budget);
    int start, n;
    bit got;
    start = mpos;
    n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      tick();
      n++;
      if (bus.OI && mpos != start) got = 1'b1;
    end
    check("arrive_open", int'(got), 1);
    check("trip_steps", mcount, trip_need);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    env_reset();
    #1;
    check("rst_state", int'(state), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_pulses", int'({bus.MU, bus.MD, bus.CUE, bus.CLE, bus.CI, bus.OUE, bus.OLE, bus.OI}), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n, m0, p0, c0;
    for (int i = 0; i < 8; i++) last_p[i] = -100;
    env_reset();
    @(negedge clk);
    do_reset();
    cyc = 0;

    // Power-up open and dwell entry
    tick();
    check("first_oi", int'(bus.OI), 1);
    check("first_ole", int'(bus.OLE), 1);
    check("first_oue", int'(bus.OUE), 0);
    tick();
    tick();
    check("dwell_by_cycle3", int'(state), 2);

    // Randomized trips with random door latency, trip length and same-side noise
    for (int t = 0; t < 8; t++) begin
      door_delay = $urandom_range(0, 4);
      trip_need  = $urandom_range(1, MAXS);
      wait_state(2, 60, "trip_dwell");
      if ($urandom_range(0, 1) == 1) begin
        if (mpos == 0) bus.GL = 1'b1; else bus.GU = 1'b1;
      end
      repeat ($urandom_range(0, 12)) tick();
      if (mpos == 0) begin
        if ($urandom_range(0, 1) == 1) bus.GU = 1'b1; else bus.CU = 1'b1;
      end else begin
        if ($urandom_range(0, 1) == 1) bus.GL = 1'b1; else bus.CL = 1'b1;
      end
      wait_arrive(120);
    end

    // Move to the upper landing with no pending calls
    {bus.GU, bus.GL, bus.CU, bus.CL} = '0;
    door_delay = 2;
    trip_need = 1;
    if (mpos == 0) begin
      wait_state(2, 60, "pre_up_dwell");
      bus.CU = 1'b1;
      wait_arrive(120);
    end
    wait_state(2, 60, "upper_dwell");

    // Same-side call only at upper: no close
    bus.GU = 1'b1;
    c0 = tot_close;
    repeat (50) tick();
    check("same_side_no_close", tot_close, c0);
    check("same_side_state", int'(state), 2);
    bus.GU = 1'b0;

    // Inner door stuck open after close command: door timeout fault
    door_freeze = 1'b1;
    m0 = tot_motor;
    bus.GL = 1'b1;
    wait_state(6, 100, "door_timeout_state");
    check("door_timeout_fault", int'(fault), 1);
    check("door_timeout_no_motor", tot_motor, m0);
    p0 = tot_pulse;
    repeat (20) tick();
    check("fault_no_pulses", tot_pulse, p0);
    check("fault_held", int'(state), 6);
    do_reset();

    // Car never arrives: MAXS motor pulses then motor fault
    door_delay = 1;
    trip_need = 99;
    wait_state(2, 60, "mfault_dwell");
    bus.CU = 1'b1;
    wait_state(6, 200, "motor_fault_state");
    check("motor_fault_steps", mcount, MAXS);
    check("motor_fault_flag", int'(fault), 1);
    do_reset();

    // Same-side call while the doors are closing
    door_delay = 3;
    trip_need = 1;
    wait_state(2, 60, "reopen_dwell");
    bus.CU = 1'b1;
    n = 0;
    while (!bus.CI && n < 100) begin
      tick();
      n++;
    end
    check("reopen_ci_seen", int'(bus.CI), 1);
    tick();
    bus.CL = 1'b1;
    n = 0;
    tick();
    while (!(bus.MU || bus.OI) && n < 60) begin
      tick();
      n++;
    end
`ifdef ELEVATOR_SEQ_REOPEN_EN
    check("reopen_oi_first", int'(bus.OI), 1);
    check("reopen_ole", int'(bus.OLE), 1);
    check("reopen_no_mu", int'(bus.MU), 0);
`else
    check("noreopen_mu_first", int'(bus.MU), 1);
    check("noreopen_no_oi", int'(bus.OI), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
